cache_fill_controller: RTL and testbench
========================================

# cache_fill_controller

Miss-handling stage between the instruction/data caches and the RAM controller. Arbitrates between I-cache and D-cache misses and fetches the missing 16-byte block as eight sequential word reads from the pipelined, fixed-latency memory. Streams each returned word into the owning cache with its word index, then pulses a per-cache done strobe so the cache can write the tag/valid bit.

## Interface
- WORDS_PER_BLOCK, 8: words per cache block; power of two; block size is 2*WORDS_PER_BLOCK bytes.
- MEM_LATENCY, 4: cycles from a memory request to its `mem_data_valid`. Informational only; the block counts returns and does not time them.

- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_cache_miss  input  1  level, held by the I-cache until its done strobe.
- i_cache_miss_address  input  16  byte address of the I-cache miss.
- d_cache_miss  input  1  level, held by the D-cache until its done strobe.
- d_cache_miss_address  input  16  byte address of the D-cache miss.
- mem_enable  output  1  read request to memory this cycle.
- mem_address  output  16  request byte address, always word-aligned.
- mem_data_valid  input  1  returned word present this cycle; returns arrive in request order.
- mem_data_out  input  16  returned word.
- fill_data  output  16  word to write into the cache; equals `mem_data_out`, passed through combinationally.
- fill_word  output  log2(WORDS_PER_BLOCK)  word index within the block.
- i_fill_write / d_fill_write  output  1  write `fill_data` at `fill_word` into the I-/D-cache data array.
- i_fill_done / d_fill_done  output  1  one-cycle strobe: block complete, write the tag and set valid.

## Operation
- States: IDLE, REQUEST, DRAIN, DONE.
- **IDLE**
  - If `d_cache_miss` is set, grant D. Otherwise, if `i_cache_miss` is set, grant I.
  - On a grant:
    - latch `owner`;
    - latch `base` = miss address with bits [log2(2*WORDS_PER_BLOCK)-1:0] cleared;
    - clear both counters;
    - go to REQUEST.
  - D has fixed priority because it is the older instruction.
- **REQUEST**
  - Each cycle: `mem_enable`=1, `mem_address` = `base` + 2*`req_cnt`, then increment `req_cnt`.
  - After the request with `req_cnt`=WORDS_PER_BLOCK-1, go to DRAIN. Requests are back-to-back and never stall.
- **Returns (REQUEST and DRAIN)**
  - On `mem_data_valid`: `fill_word` = `rsp_cnt`, assert the owner's `*_fill_write`, then increment `rsp_cnt`.
  - When the final return is accepted (`rsp_cnt`=WORDS_PER_BLOCK-1 with valid), go to DONE.
- **DONE**
  - Assert the owner's `*_fill_done` for exactly one cycle, then go to IDLE.
- **Arithmetic**
  - `req_cnt` and `rsp_cnt` are log2(WORDS_PER_BLOCK)+1 bits wide.
  - Address adds are 16-bit; wrap at 16'hFFFF is allowed but cannot occur within an aligned block.
- **Boundary conditions**
  - Miss address or miss level changes after the grant are ignored; a fill is never aborted.
  - `mem_data_valid` is ignored in IDLE and DONE, and whenever `rsp_cnt`=WORDS_PER_BLOCK. This discards stale returns after a reset.
  - A second miss arriving during a fill waits in IDLE's arbitration. The granted cache's miss must drop by the cycle after DONE, otherwise it is re-granted.
  - Both misses pending: D is served first, then I starts in the cycle after D's DONE→IDLE (one IDLE cycle between fills).
  - All outputs not listed as asserted in a state are 0.

## Timing
- Reset (async, immediate): state=IDLE, counters=0, all outputs 0 (`mem_address`=0, `fill_word`=0, `fill_data` follows `mem_data_out`).
- Cycle numbering: miss first seen high in IDLE at cycle 0.
  - Requests issue in cycles 1–8.
  - With MEM_LATENCY=4, fill writes occur in cycles 5–12.
  - Done strobe in cycle 13; IDLE in cycle 14.
- Miss penalty = WORDS_PER_BLOCK + MEM_LATENCY + 2 cycles from grant to IDLE.
- Outputs are registered-state decodes, except `fill_data`/`*_fill_write`/`fill_word`, which follow `mem_data_valid` in the same cycle.

## Test plan
- **Single D miss.** `d_cache_miss_address`=16'h1236 → requests 16'h1230, …, 16'h123E in cycles 1–8; 8 `d_fill_write` with `fill_word` 0..7 in cycles 5–12; `d_fill_done` in cycle 13; no I strobes.
- **Simultaneous misses.** I at 16'h0040, D at 16'h8008 → D block 16'h8000 is fully filled first. I requests at 16'h0040 begin the cycle after IDLE is re-entered.
- **I miss then D miss mid-fill.** D raised at cycle 3 → I fill completes untouched; D is granted at the next IDLE.
- **Address-change immunity.** Change `i_cache_miss_address` from 16'h0100 to 16'h0F00 during REQUEST → all eight requests remain in 16'h0100–16'h010E.
- **Reset mid-fill.** Assert `rst_n`=0 in cycle 6 → all outputs 0 immediately. Stale `mem_data_valid` pulses after release produce no fill writes. A new miss fills correctly.
- **Block wrap and top address.** Miss at 16'hFFFE → requests 16'hFFF0–16'hFFFE; no wrap to 16'h0000.

Source files
------------

// File: rtl/cache_fill_if.sv
// Miss/fill bundle between the caches, the fill controller and the RAM controller.
//   master : fill controller (issues memory reads, writes cache data arrays)
//   slave  : cache + memory side (raises misses, returns read data)
//   Miss inputs:  i/d_cache_miss, i/d_cache_miss_address
//   Memory side:  mem_enable, mem_address (requests); mem_data_valid, mem_data_out (returns)
//   Fill side:    fill_data, fill_word, i/d_fill_write, i/d_fill_done
interface cache_fill_if #(
  parameter int unsigned WORDS_PER_BLOCK = 8
);
  localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_BLOCK);

  logic                  i_cache_miss;
  logic [15:0]           i_cache_miss_address;
  logic                  d_cache_miss;
  logic [15:0]           d_cache_miss_address;
  logic                  mem_enable;
  logic [15:0]           mem_address;
  logic                  mem_data_valid;
  logic [15:0]           mem_data_out;
  logic [15:0]           fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic                  i_fill_write;
  logic                  d_fill_write;
  logic                  i_fill_done;
  logic                  d_fill_done;

  modport master (
    input  i_cache_miss, i_cache_miss_address, d_cache_miss, d_cache_miss_address,
    input  mem_data_valid, mem_data_out,
    output mem_enable, mem_address,
    output fill_data, fill_word, i_fill_write, d_fill_write, i_fill_done, d_fill_done
  );

  modport slave (
    output i_cache_miss, i_cache_miss_address, d_cache_miss, d_cache_miss_address,
    output mem_data_valid, mem_data_out,
    input  mem_enable, mem_address,
    input  fill_data, fill_word, i_fill_write, d_fill_write, i_fill_done, d_fill_done
  );
endinterface

// File: rtl/cache_fill_controller.sv
// Cache miss handler: arbitrates I/D misses (D first), reads the missing block as
// WORDS_PER_BLOCK back-to-back word requests, streams returned words into the owning
// cache with their word index, then pulses that cache's done strobe for one cycle.
// Returns are counted, not timed, so any fixed memory latency works.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_fill_if master (miss inputs, memory request/return, fill outputs)
// mem_enable/mem_address/*_fill_done are registered; fill_data/fill_word/*_fill_write
// follow mem_data_valid combinationally.
module cache_fill_controller #(
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_fill_if.master bus
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W  = IDX_W + 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               owner_is_d_q, owner_is_d_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic               mem_enable_q, mem_enable_d;
  logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
  logic               i_fill_done_q, i_fill_done_d;
  logic               d_fill_done_q, d_fill_done_d;
  logic               accept_c;

  // A return is consumed only while a fill is outstanding and words are still owed.
  assign accept_c = bus.mem_data_valid
                  && ((state_q == REQUEST) || (state_q == DRAIN))
                  && (rsp_cnt_q != FULL_CNT);

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    base_d       = base_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.d_cache_miss) begin
          owner_is_d_d = 1'b1;
          base_d       = bus.d_cache_miss_address & BASE_MASK;
          req_cnt_d    = '0;
          rsp_cnt_d    = '0;
          state_d      = REQUEST;
        end else if (bus.i_cache_miss) begin
          owner_is_d_d = 1'b0;
          base_d       = bus.i_cache_miss_address & BASE_MASK;
          req_cnt_d    = '0;
          rsp_cnt_d    = '0;
          state_d      = REQUEST;
        end
      end
      REQUEST: begin
        req_cnt_d = req_cnt_q + CNT_W'(1);
        if (req_cnt_q == LAST_CNT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Final return ends the fill regardless of whether requests are still issuing.
    if (accept_c) begin
      rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
      if (rsp_cnt_q == LAST_CNT) begin
        state_d = DONE;
      end
    end

    // Registered outputs are decoded from the state being entered.
    mem_enable_d  = (state_d == REQUEST);
    mem_address_d = mem_enable_d ? (base_d + (ADDR_W'(req_cnt_d) << 1)) : '0;
    i_fill_done_d = (state_d == DONE) && !owner_is_d_d;
    d_fill_done_d = (state_d == DONE) &&  owner_is_d_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_is_d_q  <= 1'b0;
      base_q        <= '0;
      req_cnt_q     <= '0;
      rsp_cnt_q     <= '0;
      mem_enable_q  <= 1'b0;
      mem_address_q <= '0;
      i_fill_done_q <= 1'b0;
      d_fill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_is_d_q  <= owner_is_d_d;
      base_q        <= base_d;
      req_cnt_q     <= req_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      mem_enable_q  <= mem_enable_d;
      mem_address_q <= mem_address_d;
      i_fill_done_q <= i_fill_done_d;
      d_fill_done_q <= d_fill_done_d;
    end
  end

  assign bus.mem_enable   = mem_enable_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.i_fill_done  = i_fill_done_q;
  assign bus.d_fill_done  = d_fill_done_q;

  // Returned word goes straight through to the owning cache.
  assign bus.fill_data    = bus.mem_data_out;
  assign bus.fill_word    = accept_c ? IDX_W'(rsp_cnt_q) : '0;
  assign bus.i_fill_write = accept_c && !owner_is_d_q;
  assign bus.d_fill_write = accept_c &&  owner_is_d_q;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: a per-cycle expectation table is built from the
// block-fill timing rules (grant at g, requests g+1.., writes g+1+LAT.., done g+PEN-1,
// free again at g+PEN) and compared against sampled outputs cycle by cycle.
module tb_cache_fill_controller;

  localparam int unsigned WPB = 8;
  localparam int unsigned LAT = 4;
  localparam int unsigned WW  = $clog2(WPB);
  localparam int          PEN = WPB + LAT + 2;
  localparam int          NC  = 1024;

  typedef struct packed {
    logic          en;
    logic [15:0]   addr;
    logic          iw;
    logic          dw;
    logic [WW-1:0] word;
    logic          idone;
    logic          ddone;
    logic [15:0]   data;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_if #(.WORDS_PER_BLOCK(WPB)) bus ();

  cache_fill_controller #(.WORDS_PER_BLOCK(WPB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  out_t        exp_q [NC];
  out_t        obs_q [NC];
  bit          acc_win [NC];
  int          cyc;
  int          free_at;
  int          d_clear_at, i_clear_at;
  logic        d_miss_m, i_miss_m;
  logic [15:0] d_addr_m, i_addr_m;
  logic [15:0] salt;
  bit          stale_en, force_stale;
  int          ret_due [$];
  logic [15:0] ret_addr [$];

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(3, 0) == 0) a[15:4] = 12'hFFF;
    return a;
  endfunction

  task automatic init_test();
    for (int c = 0; c < NC; c++) begin
      exp_q[c] = '0; obs_q[c] = '0; acc_win[c] = 1'b0;
    end
    cyc = -1; free_at = 0; d_clear_at = -1; i_clear_at = -1;
    d_miss_m = 1'b0; i_miss_m = 1'b0;
    stale_en = 1'b0; force_stale = 1'b0;
    ret_due.delete(); ret_addr.delete();
    salt = 16'($urandom);
  endtask

  // Expected effect of one block fill granted in cycle g.
  task automatic plan_fill(input int g, input bit own_d, input logic [15:0] a);
    logic [15:0] base;
    base = a & ~16'(2 * WPB - 1);
    for (int i = 0; i < int'(WPB); i++) begin
      exp_q[g + 1 + i].en   = 1'b1;
      exp_q[g + 1 + i].addr = base + 16'(2 * i);
      exp_q[g + 1 + LAT + i].iw   = !own_d;
      exp_q[g + 1 + LAT + i].dw   = own_d;
      exp_q[g + 1 + LAT + i].word = WW'(i);
      exp_q[g + 1 + LAT + i].data = memf(base + 16'(2 * i));
    end
    for (int c = g + 1; c <= g + PEN - 2; c++) acc_win[c] = 1'b1;
    if (own_d) begin
      exp_q[g + PEN - 1].ddone = 1'b1;
      d_clear_at = g + PEN;
    end else begin
      exp_q[g + PEN - 1].idone = 1'b1;
      i_clear_at = g + PEN;
    end
    free_at = g + PEN;
  endtask

  // One clock cycle: drive caches and memory, update the model, sample outputs.
  task automatic step();
    logic [15:0] rd;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc + PEN + 2 >= NC) begin
      $display("FAIL cycle_budget cyc %0d exceeds table size %0d", cyc, NC);
      $fatal(1);
    end
    if (cyc == d_clear_at) begin d_miss_m = 1'b0; d_clear_at = -1; end
    if (cyc == i_clear_at) begin i_miss_m = 1'b0; i_clear_at = -1; end
    bus.d_cache_miss         = d_miss_m;
    bus.d_cache_miss_address = d_addr_m;
    bus.i_cache_miss         = i_miss_m;
    bus.i_cache_miss_address = i_addr_m;
    if (rst_n && cyc >= free_at) begin
      if (d_miss_m)      plan_fill(cyc, 1'b1, d_addr_m);
      else if (i_miss_m) plan_fill(cyc, 1'b0, i_addr_m);
    end
    if (ret_due.size() != 0 && ret_due[0] == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_out   = memf(ret_addr[0]);
      void'(ret_due.pop_front());
      void'(ret_addr.pop_front());
    end else begin
      rd = 16'($urandom);
      bus.mem_data_out   = rd;
      exp_q[cyc].data    = rd;
      bus.mem_data_valid = !acc_win[cyc]
                         && (force_stale || (stale_en && ($urandom_range(1, 0) == 1)));
    end
    #1;
    obs_q[cyc] = '{en: bus.mem_enable, addr: bus.mem_address, iw: bus.i_fill_write,
                   dw: bus.d_fill_write, word: bus.fill_word, idone: bus.i_fill_done,
                   ddone: bus.d_fill_done, data: bus.fill_data};
    if (bus.mem_enable) begin
      ret_due.push_back(cyc + LAT);
      ret_addr.push_back(bus.mem_address);
    end
  endtask

  task automatic test_reset();
    bus.i_cache_miss = 1'b0; bus.i_cache_miss_address = 16'h0;
    bus.d_cache_miss = 1'b1; bus.d_cache_miss_address = 16'h1236;
    bus.mem_data_valid = 1'b1; bus.mem_data_out = 16'h5A5A;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.mem_enable, bus.mem_address, bus.i_fill_write, bus.d_fill_write,
           bus.fill_word, bus.i_fill_done, bus.d_fill_done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs pass %0d got en=%b addr=%h iw=%b dw=%b word=%0d idone=%b ddone=%b exp all 0",
                 k, bus.mem_enable, bus.mem_address, bus.i_fill_write, bus.d_fill_write,
                 bus.fill_word, bus.i_fill_done, bus.d_fill_done);
      end
      checks++;
      if (bus.fill_data !== 16'h5A5A) begin
        errors++;
        $display("FAIL reset_fill_data pass %0d got %h exp 5a5a", k, bus.fill_data);
      end
      repeat (2) @(posedge clk);
      #1;
    end
    bus.d_cache_miss = 1'b0; bus.mem_data_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_d();
    init_test();
    d_addr_m = 16'h1236; d_miss_m = 1'b1;
    repeat (PEN + 3) step();
    checks++;
    if (obs_q[1].addr !== 16'h1230 || obs_q[8].addr !== 16'h123E || obs_q[13].ddone !== 1'b1) begin
      errors++;
      $display("FAIL single_d_points got a1=%h a8=%h done13=%b exp 1230 123e 1", obs_q[1].addr, obs_q[8].addr, obs_q[13].ddone);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL single_d cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_simultaneous();
    init_test();
    i_addr_m = 16'h0040; i_miss_m = 1'b1;
    d_addr_m = 16'h8008; d_miss_m = 1'b1;
    repeat (2 * PEN + 3) step();
    checks++;
    if (obs_q[1].addr !== 16'h8000 || obs_q[PEN + 1].en !== 1'b1 || obs_q[PEN + 1].addr !== 16'h0040) begin
      errors++;
      $display("FAIL simultaneous_order got a1=%h en%0d=%b a%0d=%h exp 8000 1 0040",
               obs_q[1].addr, PEN + 1, obs_q[PEN + 1].en, PEN + 1, obs_q[PEN + 1].addr);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL simultaneous cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_i_then_d();
    init_test();
    i_addr_m = 16'h2468; i_miss_m = 1'b1;
    while (cyc < 2) step();
    d_addr_m = 16'h1357; d_miss_m = 1'b1;
    repeat (2 * PEN) step();
    checks++;
    if (obs_q[PEN - 1].idone !== 1'b1 || obs_q[PEN + 1].addr !== 16'h1350) begin
      errors++;
      $display("FAIL i_then_d_points got idone=%b a=%h exp 1 1350", obs_q[PEN - 1].idone, obs_q[PEN + 1].addr);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL i_then_d cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_addr_change();
    int inrange;
    init_test();
    i_addr_m = 16'h0100; i_miss_m = 1'b1;
    while (cyc < 3) step();
    i_addr_m = 16'h0F00;
    repeat (PEN) step();
    inrange = 0;
    for (int c = 0; c <= cyc; c++)
      if (obs_q[c].en && obs_q[c].addr >= 16'h0100 && obs_q[c].addr <= 16'h010E) inrange++;
    checks++;
    if (inrange != 8) begin
      errors++;
      $display("FAIL addr_change_requests got %0d exp 8", inrange);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL addr_change cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    init_test();
    i_addr_m = 16'h0300; i_miss_m = 1'b1;
    while (cyc < 5) step();
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL pre_reset cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mem_data_valid = 1'b1; bus.mem_data_out = 16'hBEEF;
    #1;
    checks++;
    if ({bus.mem_enable, bus.mem_address, bus.i_fill_write, bus.d_fill_write,
         bus.fill_word, bus.i_fill_done, bus.d_fill_done} !== '0 || bus.fill_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL reset_mid_fill got en=%b addr=%h iw=%b dw=%b word=%0d data=%h exp 0s data=beef",
               bus.mem_enable, bus.mem_address, bus.i_fill_write, bus.d_fill_write, bus.fill_word, bus.fill_data);
    end
    init_test();
    force_stale = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    force_stale = 1'b0;
    d_addr_m = 16'h4A5C; d_miss_m = 1'b1;
    repeat (PEN + 2) step();
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL post_reset cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_top_address();
    init_test();
    d_addr_m = 16'hFFFE; d_miss_m = 1'b1;
    repeat (PEN + 2) step();
    checks++;
    if (obs_q[1].addr !== 16'hFFF0 || obs_q[8].addr !== 16'hFFFE || obs_q[9].en !== 1'b0) begin
      errors++;
      $display("FAIL top_address_points got a1=%h a8=%h en9=%b exp fff0 fffe 0", obs_q[1].addr, obs_q[8].addr, obs_q[9].en);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL top_address cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_random();
    int guard;
    init_test();
    stale_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!d_miss_m && $urandom_range(9, 0) == 0) begin d_miss_m = 1'b1; d_addr_m = rand_addr(); end
      if (!i_miss_m && $urandom_range(9, 0) == 0) begin i_miss_m = 1'b1; i_addr_m = rand_addr(); end
      if ($urandom_range(7, 0) == 0) d_addr_m = rand_addr();
      if ($urandom_range(7, 0) == 0) i_addr_m = rand_addr();
      step();
    end
    guard = 0;
    while ((d_miss_m || i_miss_m || cyc < free_at) && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL random_drain got still busy after %0d cycles exp idle", guard);
    end
    for (int c = 0; c <= cyc; c++) begin
      checks++;
      if (obs_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL random cycle %0d got %h exp %h", c, obs_q[c], exp_q[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_d();
    test_simultaneous();
    test_i_then_d();
    test_addr_change();
    test_reset_mid_fill();
    test_top_address();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
